// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares a single FIFO write port among N_REQ
//   producers. Arbitration is combinational from a registered priority
//   pointer, so an accepted beat reaches the FIFO on the same clock edge as
//   its handshake. Writes are never issued while the FIFO reports full.
//
//   Optional feature macro: ARB_BURST_LOCK_EN
//     When defined, a winner keeps the grant for up to BURST_LEN beats
//     (ARB/LOCK state machine). When undefined, every beat is re-arbitrated
//     and BURST_LEN has no effect.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active-high
//     req_valid  per-requester beat valid
//     req_data   requester i data in bits [i*DWIDTH +: DWIDTH]
//     req_ready  per-requester accept, one-hot or zero
//     fifo_full  FIFO full flag
//     fifo_w_en  FIFO write enable
//     fifo_d_in  FIFO write data (0 when there is no winner)
//     grant_id   index of the current winner (0 when there is none)
//     beat_cnt   accepted-beat counter, wraps at 2^16
module fifo_wr_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DWIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_w_en,
   output logic [DWIDTH-1:0]         fifo_d_in,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic [15:0]               beat_cnt
);

   localparam int unsigned IW = $clog2(N_REQ);

   if (N_REQ < 2 || BURST_LEN < 1) begin : g_param_check
      $error("fifo_wr_arbiter: N_REQ must be >= 2 and BURST_LEN >= 1");
   end

   logic [IW-1:0] rr_ptr;
   logic          arb_found;
   logic [IW-1:0] arb_id;
   logic [IW-1:0] cand;
   logic          win_found;
   logic [IW-1:0] win_id;

   // Wrap N_REQ-1 -> 0 is explicit so non-power-of-two N_REQ works.
   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
      return (p == IW'(N_REQ - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef ARB_BURST_LOCK_EN
   localparam int unsigned CW = $clog2(BURST_LEN + 1);

   typedef enum logic {ARB, LOCK} state_t;

   state_t        state;
   logic [IW-1:0] lock_id;
   logic [CW-1:0] burst_cnt;
`endif

   // First valid requester searching rr_ptr, rr_ptr+1, ... mod N_REQ.
   always_comb begin
      arb_found = 1'b0;
      arb_id    = '0;
      cand      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = IW'((32'(rr_ptr) + k) % N_REQ);
         if (!arb_found && req_valid[cand]) begin
            arb_found = 1'b1;
            arb_id    = cand;
         end
      end
   end

   always_comb begin
      win_found = arb_found;
      win_id    = arb_id;
`ifdef ARB_BURST_LOCK_EN
      // While locked only the burst owner is eligible.
      if (state == LOCK) begin
         win_found = req_valid[lock_id];
         win_id    = lock_id;
      end
`endif
   end

   always_comb begin
      fifo_w_en = win_found && !fifo_full && !rst;
      req_ready = '0;
      req_ready[win_id] = fifo_w_en;
      fifo_d_in = '0;
      grant_id  = '0;
      if (win_found && !rst) begin
         fifo_d_in = req_data[32'(win_id) * DWIDTH +: DWIDTH];
         grant_id  = win_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         beat_cnt <= '0;
`ifdef ARB_BURST_LOCK_EN
         state     <= ARB;
         lock_id   <= '0;
         burst_cnt <= '0;
`endif
      end else begin
         if (fifo_w_en)
            beat_cnt <= beat_cnt + 16'd1;
`ifdef ARB_BURST_LOCK_EN
         // A full FIFO freezes pointer and lock state; it is not an exit.
         if (!fifo_full) begin
            case (state)
               ARB: begin
                  if (fifo_w_en) begin
                     lock_id   <= win_id;
                     burst_cnt <= CW'(1);
                     if (BURST_LEN > 1)
                        state <= LOCK;
                     else
                        rr_ptr <= next_ptr(win_id);
                  end
               end
               LOCK: begin
                  if (!req_valid[lock_id]) begin
                     state  <= ARB;
                     rr_ptr <= next_ptr(lock_id);
                  end else if (burst_cnt == CW'(BURST_LEN - 1)) begin
                     // This accepted beat completes the burst.
                     state  <= ARB;
                     rr_ptr <= next_ptr(lock_id);
                  end else begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
               end
               default: state <= ARB;
            endcase
         end
`else
         if (fifo_w_en)
            rr_ptr <= next_ptr(win_id);
`endif
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (N_REQ=4, DWIDTH=8, BURST_LEN=4).
// Lane data is fixed: lane0=10, lane1=21, lane2=A5, lane3=3C.
module tb_fifo_wr_arbiter;

   localparam int unsigned N_REQ     = 4;
   localparam int unsigned DWIDTH    = 8;
   localparam int unsigned BURST_LEN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_w_en;
   logic [7:0]  fifo_d_in;
   logic [1:0]  grant_id;
   logic [15:0] beat_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic        r;
      logic [3:0]  v;
      logic        f;
      logic [3:0]  ready;
      logic        wen;
      logic [7:0]  d;
      logic [1:0]  g;
      logic [15:0] beat;
   } vec_t;

   typedef struct {
      logic [3:0]  ready;
      logic        wen;
      logic [7:0]  d;
      logic [1:0]  g;
      logic [15:0] beat;
   } exp_t;

   exp_t sb[$];

   fifo_wr_arbiter #(
      .N_REQ    (N_REQ),
      .DWIDTH   (DWIDTH),
      .BURST_LEN(BURST_LEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .fifo_full(fifo_full),
      .fifo_w_en(fifo_w_en),
      .fifo_d_in(fifo_d_in),
      .grant_id (grant_id),
      .beat_cnt (beat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Drive one cycle, queue its expectation, compare at the falling edge.
   task automatic apply(input string tag, input logic r, input logic [3:0] v, input logic f,
                        input logic [3:0] er, input logic ew, input logic [7:0] ed,
                        input logic [1:0] eg, input logic [15:0] eb);
      exp_t e;
      exp_t o;
      rst       = r;
      req_valid = v;
      fifo_full = f;
      e = '{er, ew, ed, eg, eb};
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty got %0h want entry", tag, fifo_w_en);
      end else begin
         o = sb.pop_front();
         chk({tag, " ready"}, 32'(req_ready), 32'(o.ready));
         chk({tag, " w_en"},  32'(fifo_w_en), 32'(o.wen));
         chk({tag, " d_in"},  32'(fifo_d_in), 32'(o.d));
         chk({tag, " grant"}, 32'(grant_id),  32'(o.g));
         chk({tag, " beat"},  32'(beat_cnt),  32'(o.beat));
      end
      @(posedge clk);
      #1;
   endtask

`ifndef ARB_BURST_LOCK_EN
   vec_t tbl[24];
`endif

   int unsigned seen;

   initial begin
`ifndef ARB_BURST_LOCK_EN
      //           rst   valid  full  ready  wen   d_in   grant beat
      tbl[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd0}; // reset state
      tbl[1]  = '{1'b0, 4'h4, 1'b0, 4'h4, 1'b1, 8'hA5, 2'd2, 16'd0}; // lone req 2
      tbl[2]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd1};
      tbl[3]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 16'd0}; // all valid rotation
      tbl[4]  = '{1'b0, 4'hF, 1'b0, 4'h2, 1'b1, 8'h21, 2'd1, 16'd1};
      tbl[5]  = '{1'b0, 4'hF, 1'b0, 4'h4, 1'b1, 8'hA5, 2'd2, 16'd2};
      tbl[6]  = '{1'b0, 4'hF, 1'b0, 4'h8, 1'b1, 8'h3C, 2'd3, 16'd3};
      tbl[7]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 16'd4};
      tbl[8]  = '{1'b0, 4'hF, 1'b0, 4'h2, 1'b1, 8'h21, 2'd1, 16'd5};
      tbl[9]  = '{1'b0, 4'hF, 1'b0, 4'h4, 1'b1, 8'hA5, 2'd2, 16'd6};
      tbl[10] = '{1'b0, 4'hF, 1'b0, 4'h8, 1'b1, 8'h3C, 2'd3, 16'd7};
      tbl[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd8};
      tbl[12] = '{1'b0, 4'h2, 1'b1, 4'h0, 1'b0, 8'h21, 2'd1, 16'd8}; // full stall
      tbl[13] = '{1'b0, 4'h2, 1'b1, 4'h0, 1'b0, 8'h21, 2'd1, 16'd8};
      tbl[14] = '{1'b0, 4'h2, 1'b1, 4'h0, 1'b0, 8'h21, 2'd1, 16'd8};
      tbl[15] = '{1'b0, 4'h2, 1'b0, 4'h2, 1'b1, 8'h21, 2'd1, 16'd8};
      tbl[16] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd9}; // reset with rr_ptr=2
      tbl[17] = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 16'd0};
      tbl[18] = '{1'b0, 4'hF, 1'b0, 4'h2, 1'b1, 8'h21, 2'd1, 16'd1};
      tbl[19] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd2};
      tbl[20] = '{1'b0, 4'h9, 1'b0, 4'h8, 1'b1, 8'h3C, 2'd3, 16'd2}; // search wraps 2,3
      tbl[21] = '{1'b0, 4'h9, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 16'd3}; // 3 -> 0 wrap
      tbl[22] = '{1'b0, 4'h8, 1'b0, 4'h8, 1'b1, 8'h3C, 2'd3, 16'd4};
      tbl[23] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd5};
`endif

      req_data  = {8'h3C, 8'hA5, 8'h21, 8'h10};
      rst       = 1'b1;
      req_valid = 4'h0;
      fifo_full = 1'b0;
      @(posedge clk);
      #1;

`ifndef ARB_BURST_LOCK_EN
      for (int i = 0; i < 24; i++)
         apply($sformatf("row%0d", i), tbl[i].r, tbl[i].v, tbl[i].f,
               tbl[i].ready, tbl[i].wen, tbl[i].d, tbl[i].g, tbl[i].beat);
`else
      begin
         logic [1:0] lg [9];
         lg = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
         apply("lock rst", 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd0);
         for (int k = 0; k < 9; k++)
            apply($sformatf("lock%0d", k), 1'b0, 4'h3, 1'b0,
                  (lg[k] == 2'd1) ? 4'h2 : 4'h1, 1'b1,
                  (lg[k] == 2'd1) ? 8'h21 : 8'h10, lg[k], 16'(k));
         apply("drop rst", 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd9);
         apply("drop0", 1'b0, 4'h3, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 16'd0);
         apply("drop1", 1'b0, 4'h3, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 16'd1);
         apply("drop2", 1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 16'd2);
         apply("drop3", 1'b0, 4'h2, 1'b0, 4'h2, 1'b1, 8'h21, 2'd1, 16'd2);
      end
`endif

      // 65536 beats from requester 0: counter wraps, every cycle transfers.
      rst       = 1'b1;
      req_valid = 4'h0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 4'h1;
      seen      = 0;
      for (int n = 0; n < 65536; n++) begin
         @(negedge clk);
         if (n == 65535)
            chk("beat_cnt pre-wrap", 32'(beat_cnt), 32'h0000FFFF);
         if (fifo_w_en && req_ready == 4'h1 && fifo_d_in == 8'h10)
            seen++;
         @(posedge clk);
         #1;
      end
      req_valid = 4'h0;
      @(negedge clk);
      chk("beat_cnt wrap", 32'(beat_cnt), 32'h0);
      chk("beats accepted", seen, 32'd65536);
      chk("w_en idle", 32'(fifo_w_en), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
